// File: rtl/iram_loader_pkg.sv
// Shared constants for the IRAM loader: IRAM geometry, instruction width and FSM encoding.
package iram_loader_pkg;

    localparam int IRAM_ADDR_W = 8;
    localparam int IRAM_WORDS  = 128;
    localparam int IRAM_DATA_W = 16;
    localparam int BYTE_W      = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HI    = 3'd1;
    localparam logic [2:0] ST_LO    = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_CHK   = 3'd4;

endpackage

// File: rtl/iram_loader_asm.sv
// Byte-pair assembler: captures the high byte, then completes the word on the low byte
// and raises a one-cycle word-ready strobe that doubles as the IRAM write enable.
module iram_loader_asm
    import iram_loader_pkg::*;
#(
    parameter int DATA_W = IRAM_DATA_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              load_hi,
    input  logic              load_lo,
    input  logic [BYTE_W-1:0] in_byte,
    output logic [DATA_W-1:0] word,
    output logic              word_ready
);

    logic [BYTE_W-1:0] hi_reg;
    logic [DATA_W-1:0] word_reg;
    logic              ready_reg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hi_reg    <= '0;
            word_reg  <= '0;
            ready_reg <= 1'b0;
        end else begin
            ready_reg <= load_lo;
            if (load_hi) begin
                hi_reg <= in_byte;
            end
            // Word output only changes once both bytes are in, so WDATA holds between writes
            if (load_lo) begin
                word_reg <= {hi_reg, in_byte};
            end
        end
    end

    assign word       = word_reg;
    assign word_ready = ready_reg;

endmodule

// File: rtl/iram_loader.sv
// Byte-stream to IRAM word loader; holds the CPU in reset during a load.
// Optional trailer checksum enabled by defining IRAM_LOADER_CHECKSUM_EN.
module iram_loader
    import iram_loader_pkg::*;
#(
    parameter int ADDR_W    = IRAM_ADDR_W,
    parameter int DATA_W    = IRAM_DATA_W,
    parameter int MAX_WORDS = IRAM_WORDS
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic [ADDR_W-1:0] WORD_COUNT,
    input  logic              IN_VALID,
    input  logic [BYTE_W-1:0] IN_DATA,
    output logic              IN_READY,
    output logic              WE,
    output logic [ADDR_W-1:0] WADDR,
    output logic [DATA_W-1:0] WDATA,
    output logic              CPU_HOLD,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERROR
);

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_WORDS);

    logic [2:0]        state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] count_reg;
    logic              done_reg;
    logic              error_reg;
    logic              accept;
    logic              acc_hi;
    logic              acc_lo;
    logic              last_word;
    logic              count_zero;
    logic              count_over;

    assign accept     = IN_VALID && IN_READY;
    assign acc_hi     = accept && (state_reg == ST_HI);
    assign acc_lo     = accept && (state_reg == ST_LO);
    assign last_word  = (count_reg == ADDR_W'(1));
    assign count_zero = (WORD_COUNT == '0);
    assign count_over = ({1'b0, WORD_COUNT} > MAX_CNT);

`ifdef IRAM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] sum_reg;
    logic [BYTE_W-1:0] chk_total;
    assign chk_total = sum_reg + IN_DATA;
    assign IN_READY  = (state_reg == ST_HI) || (state_reg == ST_LO) || (state_reg == ST_CHK);
`else
    assign IN_READY  = (state_reg == ST_HI) || (state_reg == ST_LO);
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (START && !count_zero && !count_over) begin
                    state_next = ST_HI;
                end
            end
            ST_HI: begin
                if (accept) state_next = ST_LO;
            end
            ST_LO: begin
                if (accept) state_next = ST_WRITE;
            end
            ST_WRITE: begin
`ifdef IRAM_LOADER_CHECKSUM_EN
                state_next = last_word ? ST_CHK : ST_HI;
`else
                state_next = last_word ? ST_IDLE : ST_HI;
`endif
            end
`ifdef IRAM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (accept) state_next = ST_IDLE;
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            count_reg <= '0;
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
`ifdef IRAM_LOADER_CHECKSUM_EN
            sum_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    // Zero-length and oversize requests resolve immediately without leaving IDLE
                    if (START) begin
                        addr_reg  <= BASE_ADDR & ~ADDR_W'(1);
                        count_reg <= WORD_COUNT;
                        done_reg  <= count_zero;
                        error_reg <= count_over;
`ifdef IRAM_LOADER_CHECKSUM_EN
                        sum_reg   <= '0;
`endif
                    end
                end
                ST_WRITE: begin
                    addr_reg  <= addr_reg + ADDR_W'(2);
                    count_reg <= count_reg - ADDR_W'(1);
`ifndef IRAM_LOADER_CHECKSUM_EN
                    if (last_word) done_reg <= 1'b1;
`endif
                end
`ifdef IRAM_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (accept) begin
                        done_reg  <= (chk_total == '0);
                        error_reg <= (chk_total != '0);
                    end
                end
`endif
                default: ;
            endcase
`ifdef IRAM_LOADER_CHECKSUM_EN
            if (acc_hi || acc_lo) begin
                sum_reg <= sum_reg + IN_DATA;
            end
`endif
        end
    end

    iram_loader_asm #(
        .DATA_W(DATA_W)
    ) u_asm (
        .CLK       (CLK),
        .RESET     (RESET),
        .load_hi   (acc_hi),
        .load_lo   (acc_lo),
        .in_byte   (IN_DATA),
        .word      (WDATA),
        .word_ready(WE)
    );

    assign WADDR    = addr_reg;
    assign BUSY     = (state_reg != ST_IDLE);
    assign CPU_HOLD = BUSY;
    assign DONE     = done_reg;
    assign ERROR    = error_reg;

endmodule

// File: tb/tb_iram_loader.sv
// Scoreboard bench for iram_loader: expected IRAM writes are queued at stimulus time
// and popped by a monitor whenever WE pulses.
module tb_iram_loader;
    import iram_loader_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [7:0]  BASE_ADDR;
    logic [7:0]  WORD_COUNT;
    logic        IN_VALID;
    logic [7:0]  IN_DATA;
    logic        IN_READY;
    logic        WE;
    logic [7:0]  WADDR;
    logic [15:0] WDATA;
    logic        CPU_HOLD;
    logic        BUSY;
    logic        DONE;
    logic        ERROR;

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    int         n_checks = 0;
    int         n_fails  = 0;
    int         we_count = 0;
    int         we_mark;
    wr_t        exp_q[$];
    wr_t        mon_e;
    logic       prev_we = 1'b0;
    logic [7:0] pat [0:15];

    always #5 CLK = ~CLK;

    iram_loader dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .BASE_ADDR (BASE_ADDR),
        .WORD_COUNT(WORD_COUNT),
        .IN_VALID  (IN_VALID),
        .IN_DATA   (IN_DATA),
        .IN_READY  (IN_READY),
        .WE        (WE),
        .WADDR     (WADDR),
        .WDATA     (WDATA),
        .CPU_HOLD  (CPU_HOLD),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERROR     (ERROR)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (WE) begin
            we_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_we", exp_q.size(), 1);
            end else begin
                mon_e = exp_q.pop_front();
                check("waddr", {24'h0, WADDR}, {24'h0, mon_e.a});
                check("wdata", {16'h0, WDATA}, {16'h0, mon_e.d});
                $display("write addr=%h data=%h", WADDR, WDATA);
            end
            check("in_ready_low_in_write", {31'h0, IN_READY}, 0);
            check("we_single_cycle", {31'h0, prev_we}, 0);
        end
        prev_we = WE;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        IN_VALID = 1'b0;
        repeat (gap) @(negedge CLK);
        IN_VALID = 1'b1;
        IN_DATA  = b;
        for (int t = 0; t < 100; t++) begin
            if (IN_READY) begin
                @(posedge CLK);
                @(negedge CLK);
                IN_VALID = 1'b0;
                return;
            end
            @(negedge CLK);
        end
        check("in_ready_timeout", {31'h0, IN_READY}, 1);
        IN_VALID = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] base, input logic [7:0] count);
        START      = 1'b1;
        BASE_ADDR  = base;
        WORD_COUNT = count;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic load(input string name, input logic [7:0] base, input int count,
                        input int maxgap, input logic good);
        logic [7:0] sum;
        logic [7:0] a;
        wr_t        w;
        sum = 8'h00;
        a   = base & 8'hFE;
        for (int i = 0; i < count; i++) begin
            w.a = a;
            w.d = {pat[2*i], pat[2*i+1]};
            exp_q.push_back(w);
            a   = a + 8'd2;
            sum = sum + pat[2*i] + pat[2*i+1];
        end
        do_start(base, 8'(count));
        check({name, "_busy"}, {31'h0, BUSY}, 1);
        check({name, "_hold"}, {31'h0, CPU_HOLD}, 1);
        for (int i = 0; i < 2 * count; i++) begin
            send_byte(pat[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
        end
`ifdef IRAM_LOADER_CHECKSUM_EN
        check({name, "_hold_before_trailer"}, {31'h0, CPU_HOLD}, 1);
        send_byte(good ? (8'h00 - sum) : (8'h01 - sum), 0);
`else
        @(negedge CLK);
`endif
        check({name, "_done"}, {31'h0, DONE}, {31'h0, good});
        check({name, "_error"}, {31'h0, ERROR}, {31'h0, !good});
        check({name, "_busy_end"}, {31'h0, BUSY}, 0);
        check({name, "_hold_end"}, {31'h0, CPU_HOLD}, 0);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        $display("load %s base=%h count=%0d done=%b error=%b", name, base, count, DONE, ERROR);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; START = 1'b0; BASE_ADDR = 8'h00; WORD_COUNT = 8'h00;
        IN_VALID = 1'b0; IN_DATA = 8'h00;
        repeat (3) @(negedge CLK);
        check("reset_outputs", {2'b0, IN_READY, WE, WADDR, WDATA, CPU_HOLD, BUSY, DONE, ERROR}, 0);
        RESET = 1'b0;
        @(negedge CLK);

        // Basic two-word load, big-endian bytes
        pat[0] = 8'hF0; pat[1] = 8'h01; pat[2] = 8'h51; pat[3] = 8'h7F;
        load("basic", 8'h00, 2, 0, 1'b1);

        // Same load with random IN_VALID gaps
        load("gaps", 8'h00, 2, 5, 1'b1);
        load("gaps2", 8'h00, 2, 5, 1'b1);

        // Odd base forced even, address wraps FE -> 00
        pat[0] = 8'hA5; pat[1] = 8'h5A; pat[2] = 8'hC3; pat[3] = 8'h3C;
        load("wrap", 8'hFF, 2, 0, 1'b1);

        // Zero-length load
        we_mark = we_count;
        do_start(8'h20, 8'd0);
        check("cnt0_done", {31'h0, DONE}, 1);
        check("cnt0_error", {31'h0, ERROR}, 0);
        check("cnt0_busy", {31'h0, BUSY}, 0);
        repeat (3) @(negedge CLK);
        check("cnt0_no_we", we_count, we_mark);
        $display("count0 done=%b error=%b", DONE, ERROR);

        // Oversize load
        do_start(8'h20, 8'd129);
        check("cnt129_error", {31'h0, ERROR}, 1);
        check("cnt129_done", {31'h0, DONE}, 0);
        check("cnt129_busy", {31'h0, BUSY}, 0);
        repeat (3) @(negedge CLK);
        check("cnt129_no_we", we_count, we_mark);
        $display("count129 done=%b error=%b", DONE, ERROR);

        // Reset after the high byte of word 1: word 0 written, word 1 discarded
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33;
        mon_e.a = 8'h10; mon_e.d = 16'h1122;
        exp_q.push_back(mon_e);
        do_start(8'h10, 8'd2);
        send_byte(pat[0], 0);
        send_byte(pat[1], 0);
        send_byte(pat[2], 0);
        we_mark = we_count;
        RESET = 1'b1;
        @(negedge CLK);
        check("midreset_outputs", {2'b0, IN_READY, WE, WADDR, WDATA, CPU_HOLD, BUSY, DONE, ERROR}, 0);
        check("midreset_word0_written", exp_q.size(), 0);
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        check("midreset_no_we", we_count, we_mark);
        $display("midreset we_count=%0d", we_count);

        // Normal load after reset recovery
        pat[0] = 8'hDE; pat[1] = 8'hAD; pat[2] = 8'hBE; pat[3] = 8'hEF;
        pat[4] = 8'h12; pat[5] = 8'h34;
        load("after_reset", 8'h40, 3, 2, 1'b1);

`ifdef IRAM_LOADER_CHECKSUM_EN
        // Trailer FD passes, FE fails but the word is still written
        pat[0] = 8'h01; pat[1] = 8'h02;
        load("cks_ok", 8'h60, 1, 0, 1'b1);
        load("cks_bad", 8'h60, 1, 0, 1'b0);
`endif

        repeat (2) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/iram_loader.md
Name: iram_loader

Overview:
- Writer-side counterpart to the instruction memory read port: receives a byte stream (boot/debug link) and assembles 16-bit instruction words.
- Drives a synchronous write port into instruction RAM using the same byte addressing as fetch (word index = ADDR[7:1]).
- Holds the processor in reset while a load is in progress.
- Sits between the external program source and the IRAM write port.

Parameters:
- ADDR_W, 8, byte-address width of the IRAM port.
- DATA_W, 16, instruction word width; fixed at 2 bytes per word.
- MAX_WORDS, 128, IRAM depth in words.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  one-cycle pulse; begins a load; sampled only in IDLE.
- BASE_ADDR  in  8  first byte address; bit 0 ignored (forced 0).
- WORD_COUNT  in  8  number of words to load, 0..128.
- IN_VALID  in  1  byte-stream valid.
- IN_DATA  in  8  byte-stream data.
- IN_READY  out  1  loader accepts a byte when IN_VALID && IN_READY.
- WE  out  1  IRAM write enable, one-cycle pulse per word.
- WADDR  out  8  IRAM byte address, always even.
- WDATA  out  16  IRAM write data.
- CPU_HOLD  out  1  high while busy; ORed into processor RESET.
- BUSY  out  1  load in progress.
- DONE  out  1  level; last load completed without error.
- ERROR  out  1  level; last load rejected or failed.

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Word counter, address register and byte register are cleared.
- FSM states: IDLE, HI, LO, WRITE, CHK (feature only).
- IDLE:
  - IN_READY is 0.
  - On START: latch BASE_ADDR & 8'hFE and WORD_COUNT, and clear DONE and ERROR.
  - If WORD_COUNT == 0: DONE = 1 next cycle, no writes, stay IDLE.
  - If WORD_COUNT > MAX_WORDS: ERROR = 1 next cycle, no writes, stay IDLE.
  - Otherwise go to HI and set BUSY and CPU_HOLD.
- HI:
  - IN_READY = 1.
  - On accept, the byte goes to WDATA[15:8]; go to LO. First byte is the high byte (big-endian).
- LO:
  - IN_READY = 1.
  - On accept, the byte goes to WDATA[7:0]; go to WRITE.
- WRITE:
  - IN_READY = 0.
  - WE = 1 for exactly one cycle with the current WADDR and WDATA.
  - Then WADDR += 2 (mod 256, wraps 0xFE -> 0x00) and remaining count decrements.
  - If remaining count becomes 0: go to IDLE (or CHK with the feature), clear BUSY and CPU_HOLD, set DONE. Otherwise go to HI.
- Latency: WE is asserted in the cycle after the low byte is accepted. Minimum 3 cycles per word.
- IN_VALID low stalls HI/LO indefinitely, with no timeout.
- START while BUSY is ignored.
- WADDR and WDATA hold their last values outside WRITE.
- The IRAM write is treated as "mem[WADDR[7:1]] <= WDATA on posedge CLK when WE".
- RESET mid-load:
  - Returns to IDLE the next edge.
  - The partial word is discarded and WE is not asserted.
  - Words already written remain in IRAM.
- DONE and ERROR are mutually exclusive and hold until the next accepted START or RESET.

Optional Feature:
- Macro: IRAM_LOADER_CHECKSUM_EN.
- With the macro defined:
  - The loader keeps an 8-bit running sum of all data bytes.
  - After the last WRITE it enters CHK with IN_READY = 1 and accepts one trailer byte.
  - The load passes if (sum + trailer) mod 256 == 0: DONE = 1. Otherwise ERROR = 1.
  - BUSY and CPU_HOLD remain high until the trailer is accepted.
  - The IRAM contents are not rolled back on error.
- Without the macro: the CHK state and sum register are absent, and DONE is set directly after the last WRITE.

Decomposition:
- Shared package (lab5 constants): IRAM_ADDR_W = 8, IRAM_WORDS = 128, instruction width 16, and the FSM state encoding.
- One natural sub-module: iram_loader_asm, the byte-pair assembler (HI/LO byte register plus a word-ready strobe).
- The top level holds the address and count logic and the optional checksum.

Test Plan:
- BASE = 0x00, COUNT = 2, bytes F0 01 51 7F -> WE at 0x00 with F001, then at 0x02 with 517F. DONE = 1, CPU_HOLD low after the last write.
- Same load with IN_VALID gaps of 0–5 random cycles -> identical writes, each WE one cycle, IN_READY low in WRITE.
- BASE = 0xFF, COUNT = 2 -> writes at 0xFE then 0x00 (bit0 forced, wrap).
- COUNT = 0 -> DONE = 1 the next cycle, no WE, BUSY never 1. COUNT = 129 -> ERROR = 1, no WE.
- RESET asserted after the high byte of word 1 -> all outputs 0 the next cycle, no WE for word 1, word 0 remains written. A new START then works normally.
- With IRAM_LOADER_CHECKSUM_EN, bytes 01 02 plus trailer FD -> DONE. With trailer FE -> ERROR, and word 0x0102 is still written at BASE.
